am_class_seq: RTL and testbench

- Sequencer that drives one associative-memory search end to end.
- Accepts a query HV from the encoder and latches it. Pulses the AM start.
- Fetches num_class class HVs from the class-HV SRAM (fixed 1-cycle read latency) and streams them to the AM over valid/ready through a 2-entry buffer.
- Returns the winning class index to the CSR/host side on a valid/ready result port. Sits between the encoder, the class memory and the AM.

---
 rtl/am_pkg.sv | 5 +
 rtl/am_hv_buf.sv | 38 +++
 rtl/am_class_seq.sv | 105 ++++++++++
 tb/tb_am_class_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// am_pkg: shared FSM state encoding and class-HV buffer depth for the AM sequencer
package am_pkg;
  localparam int BufDepth = 2;
  typedef enum logic [2:0] {IDLE, START, FETCH, WAIT_DONE, RESULT} state_e;
endpackage

// File: rtl/am_hv_buf.sv
// am_hv_buf: 2-entry HV-wide FIFO between the class SRAM read port and the AM stream
module am_hv_buf
  import am_pkg::*;
#(
  parameter int W = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [BufDepth];
  logic wp, rp;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout  = mem[rp];
  assign full  = count == 2'(BufDepth);
  assign empty = count == 2'd0;
endmodule

// File: rtl/am_class_seq.sv
// am_class_seq: runs one AM search - latches the query, streams class HVs from SRAM, returns the winner
module am_class_seq
  import am_pkg::*;
#(
  parameter int HVDimension = 512,
  parameter int DataWidth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [HVDimension-1:0] query_hv_i,
  input  logic                   query_valid_i,
  output logic                   query_ready_o,
  input  logic [DataWidth-1:0]   num_class_i,
  input  logic [DataWidth-1:0]   base_addr_i,
  output logic                   mem_req_o,
  output logic [DataWidth-1:0]   mem_addr_o,
  input  logic [HVDimension-1:0] mem_rdata_i,
  output logic [HVDimension-1:0] am_query_hv_o,
  output logic                   am_start_o,
  input  logic                   am_busy_i,
  output logic [HVDimension-1:0] am_class_hv_o,
  output logic                   am_class_valid_o,
  input  logic                   am_class_ready_i,
  input  logic [DataWidth-1:0]   am_max_arg_idx_i,
  output logic [DataWidth-1:0]   result_idx_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   busy_o
);
  state_e state, state_nx;
  logic [DataWidth-1:0] num_q, base_q, issue_cnt, beat_cnt;
  logic inflight, issue, beat, last, accept, bf_full, bf_empty;
  logic [1:0] bf_cnt;
  assign accept = state == IDLE && query_valid_i;
  assign beat   = am_class_valid_o && am_class_ready_i;
  assign last   = beat && beat_cnt == num_q - DataWidth'(1);
  // a pop in the same cycle frees a slot, so reads keep streaming back to back
  assign issue  = state == FETCH && issue_cnt < num_q &&
                  ({1'b0, bf_cnt} + {2'b0, inflight} < 3'(BufDepth) + {2'b0, beat});
  assign mem_req_o        = issue;
  assign mem_addr_o       = base_q + issue_cnt;
  assign am_class_valid_o = !bf_empty;
  am_hv_buf #(.W(HVDimension)) u_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (inflight),
    .pop   (beat),
    .din   (mem_rdata_i),
    .dout  (am_class_hv_o),
    .full  (bf_full),
    .empty (bf_empty),
    .count (bf_cnt)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = query_valid_i ? (num_class_i == '0 ? RESULT : START) : IDLE;
      START:     state_nx = FETCH;
      FETCH:     state_nx = last ? WAIT_DONE : FETCH;
      WAIT_DONE: state_nx = am_busy_i ? WAIT_DONE : RESULT;
      RESULT:    state_nx = result_ready_i ? IDLE : RESULT;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    query_ready_o = state == IDLE;
    am_start_o    = state == START;
    busy_o        = state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      am_query_hv_o  <= '0;
      num_q          <= '0;
      base_q         <= '0;
      issue_cnt      <= '0;
      beat_cnt       <= '0;
      inflight       <= 1'b0;
      result_idx_o   <= '0;
      result_valid_o <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        am_query_hv_o  <= query_hv_i;
        num_q          <= num_class_i;
        base_q         <= base_addr_i;
        issue_cnt      <= '0;
        beat_cnt       <= '0;
        result_idx_o   <= '0;
        result_valid_o <= num_class_i == '0;
      end
      if (issue) issue_cnt <= issue_cnt + DataWidth'(1);
      if (beat) beat_cnt <= beat_cnt + DataWidth'(1);
      if (state == WAIT_DONE && !am_busy_i) begin
        result_idx_o   <= am_max_arg_idx_i;
        result_valid_o <= 1'b1;
      end
      if (state == RESULT && result_ready_i) result_valid_o <= 1'b0;
    end
  end
  overflow_guard: assert property (@(posedge clk_i) disable iff (rst_i) !(bf_full && inflight && !beat));
endmodule

// File: tb/tb_am_class_seq.sv
// tb_am_class_seq: vector-table bench with address/HV scoreboards plus SRAM and AM behavioural models
module tb_am_class_seq;
  localparam int HVD = 512;
  localparam int DW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, query_valid, query_ready, mem_req, am_start, am_busy;
  logic           am_class_valid, class_ready, result_valid, result_ready, busy;
  logic [HVD-1:0] query_hv, mem_rdata, am_query_hv, am_class_hv;
  logic [DW-1:0]  num_class, base_addr, mem_addr, am_idx, result_idx;

  am_class_seq #(.HVDimension(HVD), .DataWidth(DW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .query_hv_i       (query_hv),
    .query_valid_i    (query_valid),
    .query_ready_o    (query_ready),
    .num_class_i      (num_class),
    .base_addr_i      (base_addr),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_rdata_i      (mem_rdata),
    .am_query_hv_o    (am_query_hv),
    .am_start_o       (am_start),
    .am_busy_i        (am_busy),
    .am_class_hv_o    (am_class_hv),
    .am_class_valid_o (am_class_valid),
    .am_class_ready_i (class_ready),
    .am_max_arg_idx_i (am_idx),
    .result_idx_o     (result_idx),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .busy_o           (busy)
  );

  typedef struct {
    int n;
    int base;
    int am_idx;
    int exp_idx;
    int mode;
    int rst_at;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int errors = 0;
  int cur_n  = 0;
  int tb_beats;
  logic [DW-1:0]  addr_q[$];
  logic [HVD-1:0] hv_q[$];

  function automatic logic [HVD-1:0] hv_of(input logic [DW-1:0] a);
    logic [HVD-1:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(a) * 32'h01000193 + 32'(k) * 32'h9E3779B9 + 32'd1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [HVD-1:0] act, input logic [HVD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm, input int got);
    checks++;
    errors++;
    $display("FAIL %s got=%0d want=none", nm, got);
  endtask

  // SRAM model with a fixed one-cycle read latency; junk on idle cycles exposes spurious pushes
  always @(posedge clk) mem_rdata <= mem_req ? hv_of(mem_addr) : {16{32'hDEADBEEF}};

  // AM model: busy rises after start and drops once cur_n beats were accepted
  always @(posedge clk) begin
    if (rst) begin
      am_busy  <= 1'b0;
      tb_beats <= 0;
    end else if (am_start) begin
      am_busy  <= 1'b1;
      tb_beats <= 0;
    end else if (am_class_valid && class_ready && am_busy) begin
      tb_beats <= tb_beats + 1;
      if (tb_beats + 1 == cur_n) am_busy <= 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_qready"}, HVD'(query_ready), HVD'(1));
    chk({tag, "_busy"}, HVD'(busy), HVD'(0));
    chk({tag, "_mem_req"}, HVD'(mem_req), HVD'(0));
    chk({tag, "_am_start"}, HVD'(am_start), HVD'(0));
    chk({tag, "_cls_valid"}, HVD'(am_class_valid), HVD'(0));
    chk({tag, "_res_valid"}, HVD'(result_valid), HVD'(0));
    chk({tag, "_res_idx"}, HVD'(result_idx), HVD'(0));
    chk({tag, "_query_hv"}, am_query_hv, HVD'(0));
  endtask

  task automatic run(input vec_t v);
    int cyc, reqs, beats, starts, lat, last_cyc, max_out;
    logic stable, done, held;
    logic [HVD-1:0] qhv;
    addr_q.delete();
    hv_q.delete();
    for (int i = 0; i < v.n; i++) begin
      addr_q.push_back(DW'(v.base + i));
      hv_q.push_back(hv_of(DW'(v.base + i)));
    end
    chk("pre_qready", HVD'(query_ready), HVD'(1));
    for (int k = 0; k < 16; k++) qhv[k*32 +: 32] = $urandom;
    cur_n       = v.n;
    am_idx      = DW'(v.am_idx);
    query_hv    = qhv;
    num_class   = DW'(v.n);
    base_addr   = DW'(v.base);
    query_valid = 1'b1;
    @(posedge clk) #1;
    query_valid = 1'b0;
    num_class   = DW'($urandom);
    base_addr   = DW'($urandom);
    query_hv    = ~qhv;
    cyc = 0; reqs = 0; beats = 0; starts = 0; lat = -1; last_cyc = -1; max_out = 0;
    stable = 1'b1; done = 1'b0;
    while (!done && cyc < 200) begin
      class_ready = (v.mode == 1) ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (am_query_hv !== qhv) stable = 1'b0;
      if (mem_req) begin
        reqs++;
        if (addr_q.size() == 0) flag_fail("extra_mem_req", int'(mem_addr));
        else chk("mem_addr", HVD'(mem_addr), HVD'(addr_q.pop_front()));
      end
      if (am_start) starts++;
      if (am_class_valid && class_ready) begin
        beats++;
        last_cyc = cyc;
        if (hv_q.size() == 0) flag_fail("extra_beat", beats);
        else chk("class_hv", am_class_hv, hv_q.pop_front());
      end
      if (reqs - beats > max_out) max_out = reqs - beats;
      if (result_valid) begin
        lat  = cyc;
        done = 1'b1;
      end else if (v.rst_at > 0 && beats == v.rst_at) begin
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        #1;
        chk("rst_beats", HVD'(beats), HVD'(v.rst_at));
        check_idle_outputs("mid_rst");
        return;
      end else begin
        @(posedge clk);
        cyc++;
        #1;
      end
    end
    if (!done) begin
      flag_fail("result_timeout", cyc);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      return;
    end
    chk("beats", HVD'(beats), HVD'(v.n));
    chk("mem_reqs", HVD'(reqs), HVD'(v.n));
    chk("am_starts", HVD'(starts), HVD'(v.n > 0 ? 1 : 0));
    chk("result_idx", HVD'(result_idx), HVD'(v.exp_idx));
    chk("query_stable", HVD'(stable), HVD'(1));
    chk("max_outstanding_ok", HVD'(max_out <= 2), HVD'(1));
    if (v.exp_lat >= 0) chk("result_latency", HVD'(lat), HVD'(v.exp_lat));
    if (v.exp_lat >= 0 && v.n > 0) chk("last_beat_cycle", HVD'(last_cyc), HVD'(v.exp_lat - 2));
    if (v.mode == 2) begin
      query_valid = 1'b1;
      held = 1'b1;
      repeat (10) begin
        @(posedge clk) #2;
        if (!result_valid || result_idx !== DW'(v.exp_idx) || query_ready || !busy || am_query_hv !== qhv)
          held = 1'b0;
      end
      chk("result_hold", HVD'(held), HVD'(1));
      query_valid = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk) #1;
    result_ready = 1'b0;
    #1;
    chk("post_hs_valid", HVD'(result_valid), HVD'(0));
    chk("post_hs_qready", HVD'(query_ready), HVD'(1));
  endtask

  initial begin
    vecs[0] = '{n: 4, base: 8,   am_idx: 2, exp_idx: 2, mode: 0, rst_at: 0, exp_lat: 8};
    vecs[1] = '{n: 5, base: 20,  am_idx: 3, exp_idx: 3, mode: 1, rst_at: 0, exp_lat: -1};
    vecs[2] = '{n: 0, base: 7,   am_idx: 9, exp_idx: 0, mode: 0, rst_at: 0, exp_lat: 0};
    vecs[3] = '{n: 3, base: 254, am_idx: 1, exp_idx: 1, mode: 0, rst_at: 0, exp_lat: 7};
    vecs[4] = '{n: 2, base: 40,  am_idx: 1, exp_idx: 1, mode: 2, rst_at: 0, exp_lat: 6};
    vecs[5] = '{n: 5, base: 60,  am_idx: 4, exp_idx: 4, mode: 0, rst_at: 2, exp_lat: -1};
    vecs[6] = '{n: 3, base: 100, am_idx: 2, exp_idx: 2, mode: 0, rst_at: 0, exp_lat: 7};
    vecs[7] = '{n: 1, base: 255, am_idx: 0, exp_idx: 0, mode: 1, rst_at: 0, exp_lat: -1};
    rst = 1'b1; query_valid = 1'b0; query_hv = '0; num_class = '0; base_addr = '0;
    am_idx = '0; class_ready = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk) #1;
      run(vecs[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
